// File: rtl/au_pipe_if.sv
// Operand/result bundle for au_pipe: valid/ready input side, valid/ready result side.
// The master drives operands and out_ready; the slave (au_pipe) drives results.
interface au_pipe_if #(
    parameter int DWORD_W = 64,
    parameter int LANE_W  = 32,
    parameter int CFG_W   = 3
);
    localparam int LANES = DWORD_W / LANE_W;

    logic               in_valid;
    logic               in_ready;
    logic               Mode_in;
    logic               Sat_in;
    logic [CFG_W-1:0]   CFG_in;
    logic [DWORD_W-1:0] S0_in;
    logic [DWORD_W-1:0] S1_in;
    logic [DWORD_W-1:0] S2_in;
    logic [DWORD_W-1:0] S3_in;
    logic               out_valid;
    logic               out_ready;
    logic [DWORD_W-1:0] D0_out;
    logic [DWORD_W-1:0] D1_out;
    logic [DWORD_W-1:0] D2_out;
    logic [DWORD_W-1:0] D3_out;
    logic [LANES-1:0]   C_out;

    modport master (
        output in_valid, Mode_in, Sat_in, CFG_in,
        output S0_in, S1_in, S2_in, S3_in, out_ready,
        input  in_ready, out_valid,
        input  D0_out, D1_out, D2_out, D3_out, C_out
    );

    modport slave (
        input  in_valid, Mode_in, Sat_in, CFG_in,
        input  S0_in, S1_in, S2_in, S3_in, out_ready,
        output in_ready, out_valid,
        output D0_out, D1_out, D2_out, D3_out, C_out
    );
endinterface

// File: rtl/au_pipe.sv
// au_pipe: two-stage PASS/ADD2/ADD3/SUB2/ACC/ALD unit, full-width or lane-segmented.
// Optional per-segment saturation is compiled in with `define AU_SAT_EN.
module au_pipe #(
    parameter int DWORD_W = 64,
    parameter int LANE_W  = 32,
    parameter int CFG_W   = 3
) (
    input logic      CLK,
    input logic      RST,
    au_pipe_if.slave bus
);
    localparam int LANES = DWORD_W / LANE_W;

    localparam logic [CFG_W-1:0] OP_ADD2 = CFG_W'(1);
    localparam logic [CFG_W-1:0] OP_ADD3 = CFG_W'(2);
    localparam logic [CFG_W-1:0] OP_SUB2 = CFG_W'(3);
    localparam logic [CFG_W-1:0] OP_ACC  = CFG_W'(4);
    localparam logic [CFG_W-1:0] OP_ALD  = CFG_W'(5);

    typedef struct packed {
        logic [DWORD_W-1:0] s;
        logic [LANES-1:0]   c;
    } seg_t;

    // Carry chain is cut at every lane edge in lane mode; flag is carry (add) or borrow (sub).
    function automatic seg_t seg_add(
        input logic [DWORD_W-1:0] a,
        input logic [DWORD_W-1:0] b,
        input logic               mode,
        input logic               sub
    );
        seg_t            r;
        logic            cy;
        logic [LANE_W:0] t;
        logic [LANE_W-1:0] bl;
        r  = '0;
        cy = sub;
        for (int i = 0; i < LANES; i++) begin
            if (mode) cy = sub;
            bl = b[i*LANE_W +: LANE_W];
            if (sub) bl = ~bl;
            t  = {1'b0, a[i*LANE_W +: LANE_W]} + {1'b0, bl}
               + {{LANE_W{1'b0}}, cy};
            r.s[i*LANE_W +: LANE_W] = t[LANE_W-1:0];
            cy = t[LANE_W];
            if (mode || i == LANES-1) r.c[i] = cy ^ sub;
        end
        return r;
    endfunction

    function automatic logic [DWORD_W-1:0] sat(
        input logic [DWORD_W-1:0] v,
        input logic [LANES-1:0]   f,
        input logic               mode,
        input logic               en,
        input logic               ones
    );
        logic [DWORD_W-1:0] r;
        r = v;
        for (int i = 0; i < LANES; i++) begin
            if (en && (mode ? f[i] : f[LANES-1]))
                r[i*LANE_W +: LANE_W] = ones ? '1 : '0;
        end
        return r;
    endfunction

    logic               r_v1;
    logic               r_mode1;
    logic [CFG_W-1:0]   r_cfg1;
    logic [DWORD_W-1:0] r_s0_1;
    logic [DWORD_W-1:0] r_s1_1;
    logic [DWORD_W-1:0] r_s2_1;
    logic [DWORD_W-1:0] r_s3_1;
    logic [DWORD_W-1:0] r_ps1;
    logic [LANES-1:0]   r_pc1;

    logic               r_v2;
    logic [DWORD_W-1:0] r_d0;
    logic [DWORD_W-1:0] r_d1;
    logic [DWORD_W-1:0] r_d2;
    logic [DWORD_W-1:0] r_d3;
    logic [LANES-1:0]   r_c;
    logic [DWORD_W-1:0] r_acc;

    logic               w_adv;
    logic               w_sat;
    seg_t               w_p1;
    seg_t               w_a3;
    seg_t               w_ac;
    logic               w_is_add2;
    logic               w_is_add3;
    logic               w_is_sub2;
    logic               w_is_acc;
    logic               w_is_ald;
    logic               w_is_pass;
    logic [DWORD_W-1:0] w_res;
    logic [LANES-1:0]   w_c;
    logic               w_acc_we;

`ifdef AU_SAT_EN
    logic r_sat1;
    assign w_sat = r_sat1;
`else
    assign w_sat = 1'b0;
`endif

    assign w_adv        = !r_v2 || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v2;
    assign bus.D0_out    = r_d0;
    assign bus.D1_out    = r_d1;
    assign bus.D2_out    = r_d2;
    assign bus.D3_out    = r_d3;
    assign bus.C_out     = r_c;

    assign w_p1 = seg_add(bus.S0_in, bus.S1_in, bus.Mode_in,
                          bus.CFG_in == OP_SUB2);
    assign w_a3 = seg_add(r_ps1, r_s2_1, r_mode1, 1'b0);
    assign w_ac = seg_add(r_acc, r_s0_1, r_mode1, 1'b0);

    assign w_is_add2 = (r_cfg1 == OP_ADD2);
    assign w_is_add3 = (r_cfg1 == OP_ADD3);
    assign w_is_sub2 = (r_cfg1 == OP_SUB2);
    assign w_is_acc  = (r_cfg1 == OP_ACC);
    assign w_is_ald  = (r_cfg1 == OP_ALD);
    assign w_is_pass = !(w_is_add2 || w_is_add3 || w_is_sub2
                         || w_is_acc || w_is_ald);

    always_comb begin
        w_res    = r_s0_1;
        w_c      = '0;
        w_acc_we = 1'b0;
        unique case (1'b1)
            w_is_add2: begin
                w_c   = r_pc1;
                w_res = sat(r_ps1, r_pc1, r_mode1, w_sat, 1'b1);
            end
            w_is_add3: begin
                w_c   = r_pc1 | w_a3.c;
                w_res = sat(w_a3.s, r_pc1 | w_a3.c, r_mode1, w_sat, 1'b1);
            end
            w_is_sub2: begin
                w_c   = r_pc1;
                w_res = sat(r_ps1, r_pc1, r_mode1, w_sat, 1'b0);
            end
            w_is_acc: begin
                w_c      = w_ac.c;
                w_res    = sat(w_ac.s, w_ac.c, r_mode1, w_sat, 1'b1);
                w_acc_we = 1'b1;
            end
            w_is_ald: begin
                w_acc_we = 1'b1;
            end
            w_is_pass: begin
                w_res = r_s0_1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_v1    <= 1'b0;
            r_mode1 <= 1'b0;
            r_cfg1  <= '0;
            r_s0_1  <= '0;
            r_s1_1  <= '0;
            r_s2_1  <= '0;
            r_s3_1  <= '0;
            r_ps1   <= '0;
            r_pc1   <= '0;
`ifdef AU_SAT_EN
            r_sat1  <= 1'b0;
`endif
        end else if (w_adv) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_mode1 <= bus.Mode_in;
                r_cfg1  <= bus.CFG_in;
                r_s0_1  <= bus.S0_in;
                r_s1_1  <= bus.S1_in;
                r_s2_1  <= bus.S2_in;
                r_s3_1  <= bus.S3_in;
                r_ps1   <= w_p1.s;
                r_pc1   <= w_p1.c;
`ifdef AU_SAT_EN
                r_sat1  <= bus.Sat_in;
`endif
            end
        end
    end

    // Bubbles leave the result registers and acc untouched.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_v2  <= 1'b0;
            r_d0  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_d3  <= '0;
            r_c   <= '0;
            r_acc <= '0;
        end else if (w_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_d0 <= w_res;
                r_d1 <= r_s1_1;
                r_d2 <= r_s2_1;
                r_d3 <= r_s3_1;
                r_c  <= w_c;
                if (w_acc_we) r_acc <= w_res;
            end
        end
    end
endmodule
